// File: rtl/serial_frame_ctrl_pkg.sv
// Shared state encodings, default sizing and counter-width helper for the
// serial frame receive controller.
package serial_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_STOP  = 2'd2,
      S_BREAK = 2'd3
   } state_e;

   localparam int unsigned DEF_N   = 4;
   localparam int unsigned DEF_DIV = 1;

   // A one-cycle divider still needs a 1-bit counter to compare against.
   function automatic int unsigned div_cnt_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/serial_frame_ctrl_sipo.sv
// N-bit serial-in/parallel-out right-shift register; new bit enters the MSB,
// so after N shifts the first bit received sits in Q[0].
module sipo_shift_reg
   import serial_frame_ctrl_pkg::*;
#(
   parameter int unsigned N = DEF_N
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN,
   input  logic         in,
   output logic [N-1:0] Q
);

   logic [N-1:0] sr_q;

   generate
      if (N == 1) begin : g_single
         always_ff @(posedge CLK) begin
            if (RST) begin
               sr_q <= '0;
            end else if (EN) begin
               sr_q <= in;
            end
         end
      end else begin : g_multi
         always_ff @(posedge CLK) begin
            if (RST) begin
               sr_q <= '0;
            end else if (EN) begin
               sr_q <= {in, sr_q[N-1:1]};
            end
         end
      end
   endgenerate

   assign Q = sr_q;

endmodule

// File: rtl/serial_frame_ctrl.sv
// Framed serial receive controller: detects start bits, strobes the shift
// register for N data samples, checks the stop bit, and holds the word on a
// VALID/READY port.
module serial_frame_ctrl
   import serial_frame_ctrl_pkg::*;
#(
   parameter int unsigned N   = DEF_N,
   parameter int unsigned DIV = DEF_DIV
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         RX_EN,
   input  logic         SIN,
   input  logic         READY,
   output logic [N-1:0] DATA,
   output logic         VALID,
   output logic         BUSY,
   output logic         FRAME_ERR,
   output logic         OVERRUN
);

   localparam int unsigned   BW       = $clog2(N + 1);
   localparam int unsigned   DW       = div_cnt_width(DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   state_e        state_q;
   logic [BW-1:0] bit_cnt_q;
   logic [DW-1:0] div_cnt_q;
   logic [N-1:0]  data_q;
   logic          valid_q;
   logic          ferr_q;
   logic          ovr_q;

   logic [N-1:0]  sr;
   logic          strobe;
   logic          shift_en;
   logic          deliver;

   assign strobe   = (div_cnt_q == DIV_LAST);
   assign shift_en = (state_q == S_DATA) && strobe;
   assign deliver  = (state_q == S_STOP) && strobe && SIN;

   sipo_shift_reg #(.N(N)) u_sr (
      .CLK (CLK),
      .RST (RST),
      .EN  (shift_en),
      .in  (SIN),
      .Q   (sr)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         div_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         ferr_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (RX_EN && !SIN) begin
                  state_q   <= S_DATA;
                  bit_cnt_q <= '0;
                  div_cnt_q <= '0;
               end
            end
            S_DATA: begin
               if (strobe) begin
                  div_cnt_q <= '0;
                  if (bit_cnt_q == BIT_LAST) begin
                     state_q   <= S_STOP;
                     bit_cnt_q <= '0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (strobe) begin
                  div_cnt_q <= '0;
                  if (SIN) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_BREAK;
                     ferr_q  <= 1'b1;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            S_BREAK: begin
               if (SIN) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         // A delivery coinciding with a consume replaces the word in place.
         if (deliver) begin
            if (!valid_q || READY) begin
               data_q  <= sr;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && READY) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign DATA      = data_q;
   assign VALID     = valid_q;
   assign BUSY      = (state_q != S_IDLE);
   assign FRAME_ERR = ferr_q;
   assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Self-checking bench for serial_frame_ctrl: cycle vector table, scoreboarded
// word delivery, and directed multi-cycle sequences (overrun, reset, DIV=3).
module tb_serial_frame_ctrl;

   typedef struct packed {
      logic       sin;
      logic       rx;
      logic       rdy;
      logic       busy;
      logic       valid;
      logic       ferr;
      logic       ovr;
      logic [3:0] data;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, rx_en, ready, sin1, sin3;
   logic [3:0] data1, data3;
   logic       valid1, busy1, ferr1, ovr1;
   logic       valid3, busy3, ferr3, ovr3;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] q1[$];
   logic [3:0] q3[$];
   vec_t       tbl[$];

   always #5 clk = ~clk;

   serial_frame_ctrl #(.N(4), .DIV(1)) dut1 (
      .CLK(clk), .RST(rst), .RX_EN(rx_en), .SIN(sin1), .READY(ready),
      .DATA(data1), .VALID(valid1), .BUSY(busy1), .FRAME_ERR(ferr1), .OVERRUN(ovr1)
   );

   serial_frame_ctrl #(.N(4), .DIV(3)) dut3 (
      .CLK(clk), .RST(rst), .RX_EN(rx_en), .SIN(sin3), .READY(ready),
      .DATA(data3), .VALID(valid3), .BUSY(busy3), .FRAME_ERR(ferr3), .OVERRUN(ovr3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start bit, 4 data bits LSB first, stop bit; READY takes rdy_at_stop
   // for the stop-sample edge.
   task automatic frame1(input logic [3:0] w, input logic stop_bit, input logic rdy_at_stop);
      sin1 = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         sin1 = w[i];
         step();
      end
      sin1  = stop_bit;
      ready = rdy_at_stop;
      step();
   endtask

   // Scoreboard: a handshake seen before the edge pops the expected word.
   always @(negedge clk) begin
      logic [3:0] exp;
      if (!rst && valid1 && ready) begin
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb1_unexpected: got %0h expected no word", data1);
         end else begin
            exp = q1.pop_front();
            chk("sb1_word", {28'd0, data1}, {28'd0, exp});
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] exp;
      if (!rst && valid3 && ready) begin
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb3_unexpected: got %0h expected no word", data3);
         end else begin
            exp = q3.pop_front();
            chk("sb3_word", {28'd0, data3}, {28'd0, exp});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] w3;
      logic       b;

      // Frame 4'hD (bits 1,0,1,1) with READY=1, then frame 4'h5 with bad stop.
      //                 sin   rx    rdy   busy  valid ferr  ovr   data
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hD});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD});

      rst   = 1'b1;
      rx_en = 1'b0;
      ready = 1'b0;
      sin1  = 1'b1;
      sin3  = 1'b1;
      step();
      step();
      chk("rst_data",  {28'd0, data1}, 32'h0);
      chk("rst_valid", {31'd0, valid1}, 32'h0);
      chk("rst_busy",  {31'd0, busy1}, 32'h0);
      chk("rst_ferr",  {31'd0, ferr1}, 32'h0);
      chk("rst_ovr",   {31'd0, ovr1}, 32'h0);
      rst = 1'b0;
      step();

      q1.push_back(4'hD);
      for (int i = 0; i < tbl.size(); i++) begin
         sin1  = tbl[i].sin;
         rx_en = tbl[i].rx;
         ready = tbl[i].rdy;
         step();
         chk($sformatf("vec%0d_busy", i),  {31'd0, busy1},  {31'd0, tbl[i].busy});
         chk($sformatf("vec%0d_valid", i), {31'd0, valid1}, {31'd0, tbl[i].valid});
         chk($sformatf("vec%0d_ferr", i),  {31'd0, ferr1},  {31'd0, tbl[i].ferr});
         chk($sformatf("vec%0d_ovr", i),   {31'd0, ovr1},   {31'd0, tbl[i].ovr});
         chk($sformatf("vec%0d_data", i),  {28'd0, data1},  {28'd0, tbl[i].data});
      end

      // Back-to-back frames with READY low: second word dropped, overrun set.
      ready = 1'b0;
      q1.push_back(4'h3);
      frame1(4'h3, 1'b1, 1'b0);
      chk("b2b_first_valid", {31'd0, valid1}, 32'h1);
      frame1(4'hA, 1'b1, 1'b0);
      sin1 = 1'b1;
      chk("ovr_data",  {28'd0, data1}, 32'h3);
      chk("ovr_valid", {31'd0, valid1}, 32'h1);
      chk("ovr_flag",  {31'd0, ovr1}, 32'h1);
      chk("ovr_busy",  {31'd0, busy1}, 32'h0);
      step();
      chk("ovr_sticky", {31'd0, ovr1}, 32'h1);

      // Reset two edges into a frame aborts it and clears every output.
      sin1 = 1'b0;
      step();
      chk("abort_busy_pre", {31'd0, busy1}, 32'h1);
      sin1 = 1'b1;
      step();
      rst = 1'b1;
      step();
      q1.delete();
      chk("abort_busy",  {31'd0, busy1}, 32'h0);
      chk("abort_valid", {31'd0, valid1}, 32'h0);
      chk("abort_data",  {28'd0, data1}, 32'h0);
      chk("abort_ovr",   {31'd0, ovr1}, 32'h0);
      chk("abort_ferr",  {31'd0, ferr1}, 32'h0);
      rst = 1'b0;
      step();

      // Same back-to-back pair, READY raised for the second stop edge.
      q1.push_back(4'h3);
      frame1(4'h3, 1'b1, 1'b0);
      q1.push_back(4'hA);
      frame1(4'hA, 1'b1, 1'b1);
      sin1 = 1'b1;
      chk("b2b_rdy_data",  {28'd0, data1}, 32'hA);
      chk("b2b_rdy_valid", {31'd0, valid1}, 32'h1);
      chk("b2b_rdy_ovr",   {31'd0, ovr1}, 32'h0);
      step();
      chk("b2b_rdy_consumed", {31'd0, valid1}, 32'h0);
      chk("b2b_rdy_hold",     {28'd0, data1}, 32'hA);

      // RX_EN dropped after the start bit: frame still completes.
      rx_en = 1'b1;
      q1.push_back(4'h9);
      sin1 = 1'b0;
      step();
      rx_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w3   = 4'h9;
         sin1 = w3[i];
         step();
      end
      sin1 = 1'b1;
      step();
      chk("rxen_off_data",  {28'd0, data1}, 32'h9);
      chk("rxen_off_valid", {31'd0, valid1}, 32'h1);
      sin1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rxen_off_ignore%0d", i), {31'd0, busy1}, 32'h0);
      end
      sin1  = 1'b1;
      rx_en = 1'b1;
      step();
      chk("rxen_off_idle", {31'd0, busy1}, 32'h0);

      // DIV=3 instance: bit k held for edges E0+3(k+1)..+2, stop from E0+15.
      w3 = 4'h6;
      q3.push_back(4'h6);
      for (int e = 0; e <= 16; e++) begin
         if (e < 3)       b = 1'b0;
         else if (e >= 15) b = 1'b1;
         else             b = w3[(e - 3) / 3];
         sin3 = b;
         step();
         chk($sformatf("div3_e%0d_busy", e),  {31'd0, busy3},  {31'd0, (e < 15)});
         chk($sformatf("div3_e%0d_valid", e), {31'd0, valid3}, {31'd0, (e == 15)});
      end
      chk("div3_data", {28'd0, data3}, 32'h6);
      chk("div3_ferr", {31'd0, ferr3}, 32'h0);

      step();
      chk("sb1_drained", q1.size(), 32'd0);
      chk("sb3_drained", q3.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
